// File: rtl/ram_t0_arb.sv
// Two-port arbiter in front of a single-port synchronous RAM: a loader write
// port and an img2col read port share the RAM with tie alternation and a starvation bound.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ram_t0_arb #(
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [15:0]           busy_cnt
);

    typedef enum logic {
        PRI_W = 1'b0,
        PRI_R = 1'b1
    } pri_e;

    localparam int RW = $clog2(STARVE_MAX + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STARVE_MAX);

    pri_e            state_r;
    pri_e            state_nxt_s;
    logic [RW-1:0]   run_cnt_r;
    logic [RW-1:0]   run_cnt_nxt_s;
    logic            last_rd_r;
    logic            last_rd_nxt_s;
    logic            wr_gnt_s;
    logic            rd_gnt_s;
    logic            pick_rd_s;
    logic            both_s;
    logic            miss_s;
    logic            rd_valid_r;
    logic [15:0]     busy_cnt_r;

    assign both_s = wr_req & rd_req;

    // Grant decision: the tie winner loses only once it has used up its run.
    always_comb begin
        wr_gnt_s  = 1'b0;
        rd_gnt_s  = 1'b0;
        pick_rd_s = 1'b0;
        if (both_s) begin
            pick_rd_s = (state_r == PRI_R);
            if ((run_cnt_r == RUN_MAX) && (last_rd_r == pick_rd_s)) begin
                pick_rd_s = ~pick_rd_s;
            end else begin
                pick_rd_s = pick_rd_s;
            end
            wr_gnt_s = ~pick_rd_s;
            rd_gnt_s = pick_rd_s;
        end else begin
            wr_gnt_s = wr_req;
            rd_gnt_s = rd_req;
        end
    end

    // Next tie priority and run length of the current grant owner.
    always_comb begin
        state_nxt_s   = state_r;
        run_cnt_nxt_s = run_cnt_r;
        last_rd_nxt_s = last_rd_r;
        if (wr_gnt_s || rd_gnt_s) begin
            last_rd_nxt_s = rd_gnt_s;
            if (both_s) begin
                state_nxt_s = rd_gnt_s ? PRI_W : PRI_R;
                if (rd_gnt_s == last_rd_r) begin
                    run_cnt_nxt_s = (run_cnt_r == RUN_MAX) ? RUN_MAX : (run_cnt_r + {{(RW-1){1'b0}}, 1'b1});
                end else begin
                    run_cnt_nxt_s = {{(RW-1){1'b0}}, 1'b1};
                end
            end else begin
                run_cnt_nxt_s = {RW{1'b0}};
            end
        end else begin
            run_cnt_nxt_s = {RW{1'b0}};
        end
    end

    // RAM port mux: granted requester drives the port, otherwise all zero.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {ADDR_SIZE{1'b0}};
        ram_din  = {DATA_WIDTH{1'b0}};
        if (wr_gnt_s) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end else if (rd_gnt_s) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr;
        end else begin
            ram_en   = 1'b0;
        end
    end

    assign miss_s = (wr_req & ~wr_gnt_s) | (rd_req & ~rd_gnt_s);

    // Arbiter state, read-valid pipeline and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PRI_W;
            run_cnt_r  <= {RW{1'b0}};
            last_rd_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            busy_cnt_r <= 16'h0000;
        end else begin
            state_r    <= state_nxt_s;
            run_cnt_r  <= run_cnt_nxt_s;
            last_rd_r  <= last_rd_nxt_s;
            rd_valid_r <= rd_gnt_s;
            if (miss_s && (busy_cnt_r != 16'hFFFF)) begin
                busy_cnt_r <= busy_cnt_r + 16'd1;
            end else begin
                busy_cnt_r <= busy_cnt_r;
            end
        end
    end

    assign wr_gnt   = wr_gnt_s;
    assign rd_gnt   = rd_gnt_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = ram_dout;
    assign busy_cnt = busy_cnt_r;

endmodule

// File: doc/ram_t0_arb.md
RAM_T0_ARB -- requirements
Module: ram_t0_arb

Interface
REQ-001 Parameter ADDR_SIZE, default `ADDR_SIZE, RAM address width.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, RAM word width.
REQ-003 Parameter STARVE_MAX, default 4, max consecutive grants to one requester while the other waits.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port wr_req  input  1  loader write request; addr and data held stable until granted.
REQ-007 Port wr_addr  input  ADDR_SIZE  loader write address.
REQ-008 Port wr_data  input  DATA_WIDTH  loader write data.
REQ-009 Port wr_gnt  output  1  write accepted this cycle (combinational).
REQ-010 Port rd_req  input  1  img2col fetch request; addr held stable until granted.
REQ-011 Port rd_addr  input  ADDR_SIZE  fetch address.
REQ-012 Port rd_gnt  output  1  read accepted this cycle (combinational).
REQ-013 Port rd_valid  output  1  rd_data valid, registered.
REQ-014 Port rd_data  output  DATA_WIDTH  read data, passthrough of ram_dout.
REQ-015 Port ram_en  output  1  to RAM ena.
REQ-016 Port ram_we  output  1  to RAM wea.
REQ-017 Port ram_addr  output  ADDR_SIZE  to RAM addra.
REQ-018 Port ram_din  output  DATA_WIDTH  to RAM dina.
REQ-019 Port ram_dout  input  DATA_WIDTH  from RAM douta.
REQ-020 Port busy_cnt  output  16  saturating count of cycles with a request that was not granted.

Function
REQ-021 At most one of wr_gnt, rd_gnt SHALL be high per cycle; a grant is given only to an active request.
REQ-022 Arbiter state SHALL be one of PRI_W, PRI_R (requester that wins a tie), plus run counter run_cnt (0..STARVE_MAX).
REQ-023 Single requester active: it SHALL be granted regardless of state.
REQ-024 Both active: the requester named by state SHALL be granted, unless run_cnt == STARVE_MAX for that requester, in which case the other is granted.
REQ-025 After a grant, state SHALL switch to the opposite requester's priority when both were active; unchanged when only one was active.
REQ-026 run_cnt SHALL increment on each grant to the same requester as the previous grant while the other requests, reset to 1 on a grant to a different requester, reset to 0 on idle cycles or when the other is not requesting.
REQ-027 On a grant: ram_en=1, ram_we=wr_gnt, ram_addr and ram_din driven from granted requester; no grant: ram_en=0, ram_we=0, ram_addr/ram_din = 0.
REQ-028 rd_valid SHALL assert exactly one cycle after each rd_gnt (RAM read latency 1), for one cycle per grant; back-to-back rd_gnt gives back-to-back rd_valid.
REQ-029 rd_data SHALL equal ram_dout; only meaningful when rd_valid=1.
REQ-030 A write and read to the same address in consecutive cycles SHALL be ordered by grant order (read after write returns new data).
REQ-031 busy_cnt SHALL increment once per cycle in which any request is not granted, saturating at 16'hFFFF.

Reset
REQ-032 rst_n low SHALL asynchronously force state=PRI_W, run_cnt=0, rd_valid=0, busy_cnt=0; grants and RAM drives follow from inputs combinationally (zero with no requests).
REQ-033 Reset asserted with a read in flight SHALL drop the pending rd_valid; no rd_valid after reset release without a new rd_gnt.
REQ-034 After reset release, first arbitration cycle with both requests SHALL grant write.

Verification
REQ-035 Write-only: wr_req with addr 5, data 0xA5 -> wr_gnt=1, ram_en=1, ram_we=1, ram_addr=5, ram_din=0xA5 same cycle; busy_cnt stays 0.
REQ-036 Read latency: preload mem[3]=0x3C, rd_req addr 3 for one grant -> rd_gnt cycle N, rd_valid=1 and rd_data=0x3C cycle N+1 only.
REQ-037 Contention after reset: both request continuously -> grants alternate W,R,W,R; rd_valid pattern follows each R grant by one cycle; busy_cnt +1 per cycle.
REQ-038 RAW ordering: write addr 7 data 0x11 granted, read addr 7 granted next cycle -> rd_data=0x11.
REQ-039 Starvation bound: force both-request, check no requester gets more than STARVE_MAX (4) consecutive grants while the other waits.
REQ-040 Reset mid-read: rst_n low in cycle after rd_gnt -> rd_valid=0, busy_cnt=0, state PRI_W; subsequent contention grants write first.
